// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// First-word-fall-through FIFO of retired-instruction records {pc, instr,
// reg_addr, reg_data} for a trace consumer. When the buffer is full and no
// entry leaves in the same cycle, the incoming retire event is dropped and a
// sticky overflow flag is raised.
// Optional feature: define COMMIT_TRACE_OVF_CNT_EN to build a saturating
// 16-bit count of dropped retire events on ovf_cnt_o. Without it, ovf_cnt_o
// is tied to zero.

package riscv_pkg;
    localparam int unsigned XLEN = 32;
endpackage

module commit_trace_buffer #(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       update_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            instr_i,
    input  logic [4:0]                 reg_addr_i,
    input  logic [XLEN-1:0]            reg_data_i,
    input  logic                       flush_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [XLEN-1:0]            pc_o,
    output logic [XLEN-1:0]            instr_o,
    output logic [4:0]                 reg_addr_o,
    output logic [XLEN-1:0]            reg_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic [15:0]                ovf_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] ZERO_PTR = {PTR_W{1'b0}};

    // Entry storage; contents are never reset, occupancy is tracked by count_q
    logic [XLEN-1:0] pc_mem_q       [DEPTH];
    logic [XLEN-1:0] instr_mem_q    [DEPTH];
    logic [4:0]      reg_addr_mem_q [DEPTH];
    logic [XLEN-1:0] reg_data_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             overflow_q, overflow_d;

    logic             not_empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [XLEN-1:0]  reg_data_in_s;

    // Handshake decode: pop needs a visible head, push needs room or a same-cycle pop
    always_comb begin
        not_empty_s = (count_q != ZERO_CNT);
        full_s      = (count_q == FULL_CNT);
        pop_s       = not_empty_s && ready_i;
        push_s      = update_i && (!full_s || pop_s);
        drop_s      = update_i && full_s && !pop_s;
    end

    // Writes to x0 carry no data, so the stored value is forced to zero
    always_comb begin
        if (reg_addr_i == 5'd0) begin
            reg_data_in_s = {XLEN{1'b0}};
        end else begin
            reg_data_in_s = reg_data_i;
        end
    end

    // Next-state for pointers, occupancy and the sticky overflow flag; flush wins
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d   = ZERO_PTR;
            rd_ptr_d   = ZERO_PTR;
            count_d    = ZERO_CNT;
            overflow_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (drop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q   <= ZERO_PTR;
            rd_ptr_q   <= ZERO_PTR;
            count_q    <= ZERO_CNT;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write on an accepted push that is not cancelled by flush
    always_ff @(posedge clk_i) begin
        if (push_s && !flush_i) begin
            pc_mem_q[wr_ptr_q]       <= pc_i;
            instr_mem_q[wr_ptr_q]    <= instr_i;
            reg_addr_mem_q[wr_ptr_q] <= reg_addr_i;
            reg_data_mem_q[wr_ptr_q] <= reg_data_in_s;
        end
    end

`ifdef COMMIT_TRACE_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating count of dropped retire events, cleared by flush
    always_comb begin
        if (flush_i) begin
            ovf_cnt_d = 16'h0000;
        end else if (drop_s && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'h0001;
        end else begin
            ovf_cnt_d = ovf_cnt_q;
        end
    end

    // Dropped-event counter register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_cnt_q <= 16'h0000;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = 16'h0000;
`endif

    // Head fields fall through from storage and read as zero while empty
    always_comb begin
        if (not_empty_s) begin
            pc_o       = pc_mem_q[rd_ptr_q];
            instr_o    = instr_mem_q[rd_ptr_q];
            reg_addr_o = reg_addr_mem_q[rd_ptr_q];
            reg_data_o = reg_data_mem_q[rd_ptr_q];
        end else begin
            pc_o       = {XLEN{1'b0}};
            instr_o    = {XLEN{1'b0}};
            reg_addr_o = 5'd0;
            reg_data_o = {XLEN{1'b0}};
        end
    end

    assign valid_o    = not_empty_s;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_commit_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rstn_i;
    logic            update_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] instr_i;
    logic [4:0]      reg_addr_i;
    logic [XLEN-1:0] reg_data_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] instr_o;
    logic [4:0]      reg_addr_o;
    logic [XLEN-1:0] reg_data_o;
    logic [CW-1:0]   count_o;
    logic            overflow_o;
    logic [15:0]     ovf_cnt_o;

    always #5 clk = ~clk;

    commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn_i),
        .update_i   (update_i),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .reg_addr_i (reg_addr_i),
        .reg_data_i (reg_data_i),
        .flush_i    (flush_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .pc_o       (pc_o),
        .instr_o    (instr_o),
        .reg_addr_o (reg_addr_o),
        .reg_data_o (reg_data_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .ovf_cnt_o  (ovf_cnt_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    ent_t q[$];
    bit   m_ovf;
    int   m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_ovf_cnt();
`ifdef COMMIT_TRACE_OVF_CNT_EN
        return 16'(m_cnt);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_clear();
        q.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    // Apply one clock edge worth of behaviour to the model
    task automatic model_edge(input bit upd, input ent_t e, input bit rdy, input bit fl);
        bit pop;
        bit acc;
        if (fl) begin
            model_clear();
        end else begin
            pop = (q.size() > 0) && rdy;
            acc = 1'b0;
            if (upd) begin
                if (q.size() < DEPTH || pop) begin
                    acc = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic check_outputs();
        check_val("valid", 64'(valid_o), 64'(q.size() > 0));
        check_val("count", 64'(count_o), 64'(q.size()));
        check_val("overflow", 64'(overflow_o), 64'(m_ovf));
        check_val("ovf_cnt", 64'(ovf_cnt_o), 64'(exp_ovf_cnt()));
        if (q.size() > 0) begin
            check_val("head_pc", 64'(pc_o), 64'(q[0].pc));
            check_val("head_instr", 64'(instr_o), 64'(q[0].instr));
            check_val("head_addr", 64'(reg_addr_o), 64'(q[0].addr));
            check_val("head_data", 64'(reg_data_o), 64'(q[0].data));
        end else begin
            check_val("idle_pc", 64'(pc_o), 64'h0);
            check_val("idle_instr", 64'(instr_o), 64'h0);
            check_val("idle_addr", 64'(reg_addr_o), 64'h0);
            check_val("idle_data", 64'(reg_data_o), 64'h0);
        end
    endtask

    // Called at a falling edge: drive, check pre-edge outputs, clock, update model
    task automatic drive_cycle(input bit upd, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [4:0] ra, input logic [31:0] rd,
                               input bit rdy, input bit fl);
        ent_t e;
        update_i   = upd;
        pc_i       = pc;
        instr_i    = instr;
        reg_addr_i = ra;
        reg_data_i = rd;
        ready_i    = rdy;
        flush_i    = fl;
        e.pc    = pc;
        e.instr = instr;
        e.addr  = ra;
        e.data  = (ra == 5'd0) ? 32'h0 : rd;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(upd, e, rdy, fl);
        @(negedge clk);
    endtask

    task automatic check_reset_zero(input string tag);
        check_val({tag, "_valid"}, 64'(valid_o), 64'h0);
        check_val({tag, "_count"}, 64'(count_o), 64'h0);
        check_val({tag, "_ovf"}, 64'(overflow_o), 64'h0);
        check_val({tag, "_ovfcnt"}, 64'(ovf_cnt_o), 64'h0);
        check_val({tag, "_pc"}, 64'(pc_o), 64'h0);
        check_val({tag, "_data"}, 64'(reg_data_o), 64'h0);
    endtask

    // Called at a falling edge; an edge occurs with reset low and update high
    task automatic apply_reset();
        rstn_i     = 1'b0;
        update_i   = 1'b1;
        ready_i    = 1'b0;
        flush_i    = 1'b0;
        pc_i       = $urandom;
        instr_i    = $urandom;
        reg_addr_i = 5'd3;
        reg_data_i = $urandom;
        #1;
        check_reset_zero("rst_a");
        @(posedge clk);
        #1;
        check_reset_zero("rst_b");
        @(negedge clk);
        rstn_i   = 1'b1;
        update_i = 1'b0;
        model_clear();
    endtask

    task automatic idle(input bit rdy);
        drive_cycle(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, rdy, 1'b0);
    endtask

    task automatic push(input logic [31:0] pc, input bit rdy);
        drive_cycle(1'b1, pc, pc ^ 32'h0000_0013, 5'(pc[6:2] | 5'd1), pc + 32'h11, rdy, 1'b0);
    endtask

    task automatic do_flush();
        drive_cycle(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rstn_i     = 1'b0;
        update_i   = 1'b0;
        pc_i       = '0;
        instr_i    = '0;
        reg_addr_i = '0;
        reg_data_i = '0;
        ready_i    = 1'b0;
        flush_i    = 1'b0;
        model_clear();

        @(negedge clk);
        apply_reset();

        // Single entry with latency 1
        drive_cycle(1'b1, 32'h8000_0000, 32'h0050_0093, 5'd1, 32'h5, 1'b0, 1'b0);
        check_val("single_valid", 64'(valid_o), 64'h1);
        check_val("single_pc", 64'(pc_o), 64'h8000_0000);
        check_val("single_instr", 64'(instr_o), 64'h0050_0093);
        check_val("single_addr", 64'(reg_addr_o), 64'h1);
        check_val("single_data", 64'(reg_data_o), 64'h5);
        check_val("single_count", 64'(count_o), 64'h1);
        idle(1'b0);
        idle(1'b1);

        // x0 writes store zero data
        drive_cycle(1'b1, 32'h8000_0004, 32'h0000_0013, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_val("x0_valid", 64'(valid_o), 64'h1);
        check_val("x0_data", 64'(reg_data_o), 64'h0);
        idle(1'b1);

        // Overflow: 10 updates into 8 entries, drain in order
        do_flush();
        for (int i = 0; i < 10; i++) push(32'h0000_1000 + 32'(4 * i), 1'b0);
        check_val("ovf_count", 64'(count_o), 64'd8);
        check_val("ovf_flag", 64'(overflow_o), 64'h1);
`ifdef COMMIT_TRACE_OVF_CNT_EN
        check_val("ovf_cnt", 64'(ovf_cnt_o), 64'd2);
`else
        check_val("ovf_cnt", 64'(ovf_cnt_o), 64'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            check_val("ovf_drain_pc", 64'(pc_o), 64'h0000_1000 + 64'(4 * i));
            idle(1'b1);
        end
        check_val("ovf_drain_empty", 64'(valid_o), 64'h0);
        check_val("ovf_sticky", 64'(overflow_o), 64'h1);

        // Full buffer with simultaneous push and pop
        do_flush();
        for (int i = 0; i < 8; i++) push(32'h0000_2000 + 32'(4 * i), 1'b0);
        push(32'h0000_2100, 1'b1);
        check_val("fpp_count", 64'(count_o), 64'd8);
        check_val("fpp_ovf", 64'(overflow_o), 64'h0);
        for (int i = 1; i < 8; i++) begin
            check_val("fpp_drain_pc", 64'(pc_o), 64'h0000_2000 + 64'(4 * i));
            idle(1'b1);
        end
        check_val("fpp_last_pc", 64'(pc_o), 64'h0000_2100);
        idle(1'b1);

        // Flush with 3 entries and overflow set, concurrent update ignored
        for (int i = 0; i < 9; i++) push(32'h0000_3000 + 32'(4 * i), 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        check_val("fl_pre_count", 64'(count_o), 64'd3);
        check_val("fl_pre_ovf", 64'(overflow_o), 64'h1);
        drive_cycle(1'b1, 32'h0000_3F00, 32'h1, 5'd2, 32'h2, 1'b1, 1'b1);
        check_val("fl_count", 64'(count_o), 64'd0);
        check_val("fl_valid", 64'(valid_o), 64'h0);
        check_val("fl_ovf", 64'(overflow_o), 64'h0);
        check_val("fl_ovfcnt", 64'(ovf_cnt_o), 64'h0);
        idle(1'b0);

        // Asynchronous reset mid-cycle with 5 entries
        for (int i = 0; i < 5; i++) push(32'h0000_4000 + 32'(4 * i), 1'b0);
        check_val("ar_pre_count", 64'(count_o), 64'd5);
        #2;
        rstn_i = 1'b0;
        #1;
        check_val("ar_valid", 64'(valid_o), 64'h0);
        check_val("ar_count", 64'(count_o), 64'h0);
        check_val("ar_pc", 64'(pc_o), 64'h0);
        @(negedge clk);
        apply_reset();
        idle(1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            bit          upd;
            bit          rdy;
            bit          fl;
            logic [4:0]  ra;
            upd = ($urandom_range(0, 9) < 6);
            rdy = (c % 100 < 40) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 99) < 2);
            ra  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive_cycle(upd, $urandom, $urandom, ra, $urandom, rdy, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter XLEN, default riscv_pkg::XLEN, data/PC/instruction width.
REQ-002 SHALL have parameter DEPTH, default 8, number of FIFO entries (power of two, >= 2).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rstn_i, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port update_i, input, 1, core retired one instruction this cycle.
REQ-006 SHALL have port pc_i, input, XLEN, retired PC.
REQ-007 SHALL have port instr_i, input, XLEN, retired instruction word.
REQ-008 SHALL have port reg_addr_i, input, 5, destination register (0 = no write).
REQ-009 SHALL have port reg_data_i, input, XLEN, destination write data.
REQ-010 SHALL have port flush_i, input, 1, synchronous clear of buffer and flags.
REQ-011 SHALL have port valid_o, output, 1, head entry available.
REQ-012 SHALL have port ready_i, input, 1, consumer accepts head entry.
REQ-013 SHALL have ports pc_o / instr_o / reg_data_o (output, XLEN) and reg_addr_o (output, 5), head entry fields.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH)+1, occupied entries.
REQ-015 SHALL have port overflow_o, output, 1, sticky: at least one retire event dropped.
REQ-016 SHALL have port ovf_cnt_o, output, 16, number of dropped retire events.

Function
REQ-017 SHALL store one entry {pc, instr, reg_addr, reg_data} per cycle in which update_i=1 and the push is accepted.
REQ-018 SHALL force the stored reg_data to 0 when reg_addr_i=0.
REQ-019 SHALL accept a push when count_o<DEPTH, or when count_o=DEPTH and a pop occurs in the same cycle.
REQ-020 SHALL pop the head when valid_o=1 and ready_i=1; ready_i while valid_o=0 has no effect.
REQ-021 SHALL assert valid_o exactly when count_o>0, with head fields driven combinationally from storage (first-word fall-through).
REQ-022 SHALL make a push into an empty buffer visible on valid_o one cycle after the update_i edge (latency 1, no input-to-output bypass).
REQ-023 SHALL hold valid_o and all head fields stable while valid_o=1 and ready_i=0.
REQ-024 SHALL, on simultaneous accepted push and pop, leave count_o unchanged and preserve FIFO order.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL drop a rejected push (full, no pop): storage unchanged, overflow_o set to 1 on the next edge.
REQ-027 SHALL keep overflow_o at 1 until reset or flush_i.
REQ-028 SHALL, when flush_i=1, on the next edge set count_o=0, reset both pointers and clear overflow_o and ovf_cnt_o; flush_i has priority over any same-cycle push or pop.
REQ-029 SHALL keep pc_o/instr_o/reg_addr_o/reg_data_o at 0 while valid_o=0.

Reset
REQ-030 SHALL, while rstn_i=0, immediately drive valid_o=0, count_o=0, overflow_o=0, ovf_cnt_o=0, and all head fields to 0, and reset both pointers to 0.
REQ-031 SHALL discard all buffered entries when reset asserts mid-operation; storage contents need not be cleared.
REQ-032 SHALL ignore update_i during the first edge after rstn_i deasserts only if rstn_i was low at that edge.

Configuration
REQ-033 SHALL, with macro COMMIT_TRACE_OVF_CNT_EN defined, increment ovf_cnt_o by 1 per dropped push, saturating at 16'hFFFF.
REQ-034 SHALL, without COMMIT_TRACE_OVF_CNT_EN, tie ovf_cnt_o to 0 and contain no counter logic; overflow_o is unaffected.

Verification
REQ-035 SHALL verify single entry: reset, then update_i=1 for one cycle (pc=0x80000000, instr=0x00500093, x1, 0x5), ready_i=0 -> valid_o=1 next cycle with those fields, count_o=1.
REQ-036 SHALL verify x0 masking: push reg_addr=0, reg_data=0xDEADBEEF -> head reg_data_o=0.
REQ-037 SHALL verify overflow: DEPTH=8, ready_i=0, 10 consecutive updates -> count_o=8, overflow_o=1, ovf_cnt_o=2 (macro defined) or 0 (undefined); drain yields the first 8 PCs in order.
REQ-038 SHALL verify full push+pop: buffer full, update_i=1 and ready_i=1 same cycle -> count_o stays 8, overflow_o stays 0, new entry appears last.
REQ-039 SHALL verify flush: 3 entries with overflow_o=1, flush_i=1 with update_i=1 -> next cycle count_o=0, valid_o=0, overflow_o=0.
REQ-040 SHALL verify asynchronous reset: rstn_i low mid-cycle with 5 entries -> valid_o=0 and count_o=0 before the next clock edge.
